// File: rtl/ifu_queue.sv
// Superscalar instruction fetch queue: up to WR_NUM words in and RD_NUM oldest words out per cycle.
// Pointers carry one extra wrap bit so full and empty stay distinct at equal indices.
module ifu_queue #(
  parameter int DATA_LEN   = 32,
  parameter int AddR_Width = 4,
  parameter int WR_NUM     = 2,
  parameter int RD_NUM     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WR_NUM-1:0]            wvalid,
  input  logic [WR_NUM*DATA_LEN-1:0]   wdata,
  output logic                         wready,
  output logic [RD_NUM-1:0]            rvalid,
  output logic [RD_NUM*DATA_LEN-1:0]   rdata,
  input  logic [RD_NUM-1:0]            rready,
  output logic [AddR_Width:0]          count,
  output logic                         full,
  output logic                         empty
);

  localparam int Word_Depth = 2 ** AddR_Width;
  localparam int PW         = AddR_Width + 1;

  logic [DATA_LEN-1:0]   mem_reg [Word_Depth];
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         free_slots;
  logic [PW-1:0]         n_w, n_r;
  logic [WR_NUM-1:0]     w_en;
  logic [RD_NUM-1:0]     r_take;
  logic [AddR_Width-1:0] wr_idx [WR_NUM];
  logic [AddR_Width-1:0] rd_idx [RD_NUM];

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign full       = (count == PW'(Word_Depth));
  assign empty      = (count == '0);
  assign free_slots = PW'(Word_Depth) - count;
  // Backpressure looks at current occupancy only; a same-cycle read never frees room early.
  assign wready     = (free_slots >= PW'(WR_NUM));

  // Only the unbroken run of requests starting at slot 0 is honoured.
  always_comb begin
    logic run;
    run  = 1'b1;
    w_en = '0;
    n_w  = '0;
    for (int i = 0; i < WR_NUM; i++) begin
      run     = run & wvalid[i];
      w_en[i] = run & wready;
      n_w     = n_w + PW'(w_en[i]);
    end
  end

  always_comb begin
    logic run;
    run    = 1'b1;
    r_take = '0;
    n_r    = '0;
    for (int i = 0; i < RD_NUM; i++) begin
      run       = run & rready[i] & rvalid[i];
      r_take[i] = run;
      n_r       = n_r + PW'(r_take[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < WR_NUM; gi++) begin : g_wr_idx
      assign wr_idx[gi] = wr_ptr_reg[AddR_Width-1:0] + AddR_Width'(gi);
    end
    for (genvar gi = 0; gi < RD_NUM; gi++) begin : g_rd_slot
      assign rd_idx[gi]                          = rd_ptr_reg[AddR_Width-1:0] + AddR_Width'(gi);
      assign rvalid[gi]                          = (count > PW'(gi));
      assign rdata[gi*DATA_LEN +: DATA_LEN]      = mem_reg[rd_idx[gi]];
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg + n_w;
    rd_ptr_next = rd_ptr_reg + n_r;
    if (flush) begin
      wr_ptr_next = rd_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage is never cleared; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < WR_NUM; i++) begin
        if (w_en[i]) begin
          mem_reg[wr_idx[i]] <= wdata[i*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

endmodule

// File: doc/ifu_queue.md
Name: ifu_queue

Overview:
- Multi-port instruction fetch queue between the fetch/predecode stage and decode.
- Accepts up to WR_NUM instruction words per cycle and presents up to RD_NUM oldest words per cycle to decode, each with per-slot valid.
- Provides occupancy count, full/empty flags, all-or-nothing write backpressure and single-cycle flush for redirects.
- Generalises the single-port fetch FIFO to superscalar width with an explicit handshake.

Parameters:
- DATA_LEN, 32, width of one queue entry.
- AddR_Width, 4, log2 of depth; Word_Depth = 2**AddR_Width (16).
- WR_NUM, 2, write slots per cycle; 1 <= WR_NUM <= Word_Depth.
- RD_NUM, 2, read slots per cycle; 1 <= RD_NUM <= Word_Depth.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all queued entries.
- wvalid  input  WR_NUM  per-slot write request; slot 0 is oldest.
- wdata  input  WR_NUM*DATA_LEN  slot i occupies bits [i*DATA_LEN +: DATA_LEN].
- wready  output  1  queue can accept a full group of WR_NUM entries this cycle.
- rvalid  output  RD_NUM  rvalid[i] = 1 when count > i.
- rdata  output  RD_NUM*DATA_LEN  slot i = entry at read pointer + i (mod depth).
- rready  input  RD_NUM  per-slot consume request from decode.
- count  output  AddR_Width+1  current number of valid entries, 0..Word_Depth.
- full  output  1  count == Word_Depth.
- empty  output  1  count == 0.

Behaviour:
- Storage: Word_Depth x DATA_LEN register array.
- Pointers: wr_ptr and rd_ptr, each AddR_Width+1 bits. Index uses the low AddR_Width bits; increments wrap modulo 2**(AddR_Width+1).
- count = wr_ptr - rd_ptr, combinational. full, empty and rvalid are derived from count.
- wready = (Word_Depth - count) >= WR_NUM. It is computed from the current count only; same-cycle reads do not raise wready.
- Write count n_w:
  - n_w = number of consecutive 1s in wvalid starting at bit 0; bits above the first 0 are ignored.
  - n_w is forced to 0 when wready = 0.
  - Slot i (i < n_w) is written to index wr_ptr+i; wr_ptr += n_w.
- Read count n_r:
  - n_r = number of consecutive 1s in (rready & rvalid) starting at bit 0.
  - rd_ptr += n_r.
- rdata/rvalid are combinational from array and pointers.
- No write-to-read bypass: data written in cycle t is visible on rdata no earlier than cycle t+1.
- Simultaneous read and write in one cycle are both performed; count changes by n_w - n_r.
- Priority: rst > flush > normal operation.
- flush: wr_ptr <= rd_ptr and the array is not cleared. Writes and reads presented in the flush cycle are dropped. From the next cycle, count = 0, empty = 1 and rvalid = 0.
- Reset values: wr_ptr = rd_ptr = 0, so count = 0, empty = 1, full = 0, rvalid = 0.
  - wready = 1 after reset, since WR_NUM <= Word_Depth.
  - rdata is undefined when rvalid is low; the bench must not check it.
- Reset mid-operation: all queued entries are lost. The array contents are don't-care.
- Wrap-around: a group may straddle index Word_Depth-1 -> 0; slot order must be preserved.
- Pointer-MSB difference makes full vs empty unambiguous at equal indices.

Test Plan:
- Reset then idle -> count = 0, empty = 1, full = 0, wready = 1, rvalid = 2'b00.
- Fill (defaults): wvalid = 2'b11 with data pairs (k, k+1) for 8 cycles, rready = 0 -> count = 16, full = 1, wready = 0.
  - wready also = 0 at count = 15; check by writing wvalid = 2'b01 from a count of 14.
- Drain: at full, rready = 2'b11 -> rdata slot0/slot1 return 0,1 then 2,3 in order; count decreases 2 per cycle; empty = 1 after 8 cycles.
- Wrap: advance pointers to index 15, write 0xA,0xB -> 0xA stored at index 15 and 0xB at index 0; next cycle rdata = {0xB,0xA} with rvalid = 2'b11.
- Gaps and simultaneity:
  - wvalid = 2'b10 -> nothing written.
  - rready = 2'b10 -> nothing consumed.
  - Count 5 with wvalid = 2'b11 and rready = 2'b01 -> count = 6 next cycle.
- Flush/reset priority:
  - Count 7 with flush, wvalid = 2'b11 and rready = 2'b11 -> count = 0 next cycle, empty = 1, no data retained.
  - rst and flush together -> pointers = 0.
